// File: rtl/floating_add_mul.sv
// Single-cycle binary32 adder/multiplier with registered result; subnormals flush to zero.
// Define FLOATING_ROUND_NEAREST_EN for round-to-nearest-even, otherwise results truncate.
module floating_add_mul #(
   parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        valid_out
);

   logic        sa, sb;
   logic [7:0]  ea, eb;
   logic [23:0] ma, mb;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign sa     = a[31];
   assign sb     = b[31];
   assign ea     = a[30:23];
   assign eb     = b[30:23];
   assign ma     = {1'b1, a[22:0]};
   assign mb     = {1'b1, b[22:0]};
   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);
   assign a_inf  = (ea == 8'hFF) && (a[22:0] == '0);
   assign b_inf  = (eb == 8'hFF) && (b[22:0] == '0);
   assign a_nan  = (ea == 8'hFF) && (a[22:0] != '0);
   assign b_nan  = (eb == 8'hFF) && (b[22:0] != '0);

   // add path: 27-bit working format = 24-bit mantissa, guard, round, sticky
   logic               a_big, sl, ss;
   logic [7:0]         el, es, ediff;
   logic [23:0]        ml, ms;
   logic [5:0]         sh_amt;
   logic [49:0]        sh_vec;
   logic [26:0]        al_large, al_small, add_norm;
   logic [27:0]        sum;
   logic [4:0]         lz;
   logic signed [9:0]  add_exp;
   logic               add_zero;

   always_comb begin
      a_big    = (a[30:0] >= b[30:0]);
      el       = a_big ? ea : eb;
      es       = a_big ? eb : ea;
      ml       = a_big ? ma : mb;
      ms       = a_big ? mb : ma;
      sl       = a_big ? sa : sb;
      ss       = a_big ? sb : sa;
      ediff    = el - es;
      // beyond 40 the hidden bit still lands in the sticky field
      sh_amt   = (ediff > 8'd40) ? 6'd40 : ediff[5:0];
      sh_vec   = {ms, 26'b0} >> sh_amt;
      al_small = {sh_vec[49:24], |sh_vec[23:0]};
      al_large = {ml, 3'b000};
      if (sl == ss)
         sum = {1'b0, al_large} + {1'b0, al_small};
      else
         sum = {1'b0, al_large} - {1'b0, al_small};
      lz = '0;
      for (int unsigned i = 0; i < 27; i++)
         if (sum[i]) lz = 5'(26 - i);
      if (sum[27]) begin
         add_norm = {sum[27:2], |sum[1:0]};
         add_exp  = $signed({2'b00, el}) + 10'sd1;
      end else begin
         add_norm = sum[26:0] << lz;
         add_exp  = $signed({2'b00, el}) - $signed({5'b00000, lz});
      end
      add_zero = (sum == '0);
   end

   logic [47:0]        prod;
   logic signed [9:0]  mul_exp_base, mul_exp;
   logic [26:0]        mul_norm;

   always_comb begin
      prod         = ma * mb;
      mul_exp_base = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      if (prod[47]) begin
         mul_norm = {prod[47:22], |prod[21:0]};
         mul_exp  = mul_exp_base + 10'sd1;
      end else begin
         mul_norm = {prod[46:21], |prod[20:0]};
         mul_exp  = mul_exp_base;
      end
   end

   logic               pre_sign, rnd_up;
   logic [23:0]        pre_mant;
   logic [2:0]         pre_grs;
   logic signed [9:0]  pre_exp, rnd_exp;
   logic [24:0]        rnd_mant;
   logic [22:0]        rnd_frac;
   logic [31:0]        rounded, calc;

`ifndef FLOATING_ROUND_NEAREST_EN
   logic grs_unused;
   assign grs_unused = ^pre_grs;
`endif

   always_comb begin
      pre_sign = op ? (sa ^ sb) : sl;
      pre_mant = op ? mul_norm[26:3] : add_norm[26:3];
      pre_grs  = op ? mul_norm[2:0] : add_norm[2:0];
      pre_exp  = op ? mul_exp : add_exp;
`ifdef FLOATING_ROUND_NEAREST_EN
      rnd_up   = pre_grs[2] & (pre_grs[1] | pre_grs[0] | pre_mant[0]);
`else
      rnd_up   = 1'b0;
`endif
      rnd_mant = {1'b0, pre_mant} + {24'b0, rnd_up};
      if (rnd_mant[24]) begin
         rnd_exp  = pre_exp + 10'sd1;
         rnd_frac = rnd_mant[23:1];
      end else begin
         rnd_exp  = pre_exp;
         rnd_frac = rnd_mant[22:0];
      end
      if (rnd_exp >= 10'sd255)
         rounded = {pre_sign, 8'hFF, 23'b0};
      else if (rnd_exp <= 10'sd0)
         rounded = {pre_sign, 31'b0};
      else
         rounded = {pre_sign, rnd_exp[7:0], rnd_frac};
   end

   always_comb begin
      calc = rounded;
      if (a_nan || b_nan ||
          (op  && ((a_inf && b_zero) || (a_zero && b_inf))) ||
          (!op && a_inf && b_inf && (sa != sb)))
         calc = NAN_VALUE;
      else if (a_inf || b_inf)
         calc = op ? {sa ^ sb, 8'hFF, 23'b0} : (a_inf ? a : b);
      else if (op && (a_zero || b_zero))
         calc = {sa ^ sb, 31'b0};
      else if (!op && a_zero && b_zero)
         calc = {sa & sb, 31'b0};
      else if (!op && a_zero)
         calc = b;
      else if (!op && b_zero)
         calc = a;
      else if (!op && add_zero)
         calc = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= valid_in;
         if (valid_in)
            result <= calc;
      end
   end

endmodule

// File: tb/tb_floating_add_mul.sv
// Directed and constrained-random checks for floating_add_mul; honours FLOATING_ROUND_NEAREST_EN.
module tb_floating_add_mul;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic        op = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] result;
   logic        valid_out;

   int n_chk = 0;
   int n_bad = 0;

   floating_add_mul #(.NAN_VALUE(32'h7FC0_0000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .op        (op),
      .a         (a),
      .b         (b),
      .result    (result),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // reference via exact double arithmetic, then rounded to binary32 by bit manipulation
   function automatic logic [31:0] ref_fp(input logic op_i, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] dx, dy, dr;
      real         rx, ry, rr;
      int          e;
      logic [24:0] m;
`ifdef FLOATING_ROUND_NEAREST_EN
      logic [28:0] rem;
`endif
      dx = {x[31], 11'({3'b000, x[30:23]} + 11'd896), x[22:0], 29'b0};
      dy = {y[31], 11'({3'b000, y[30:23]} + 11'd896), y[22:0], 29'b0};
      rx = $bitstoreal(dx);
      ry = $bitstoreal(dy);
      rr = op_i ? rx * ry : rx + ry;
      dr = $realtobits(rr);
      if (dr[62:0] == '0) return {dr[63], 31'b0};
      e = int'(dr[62:52]) - 896;
      m = {2'b01, dr[51:29]};
`ifdef FLOATING_ROUND_NEAREST_EN
      rem = dr[28:0];
      if (rem[28] && ((rem[27:0] != '0) || m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
`endif
      return {dr[63], 8'(e), m[22:0]};
   endfunction

   task automatic apply(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp);
      @(negedge clk);
      op = o; a = x; b = y; valid_in = 1'b1;
      @(posedge clk);
      #1;
      chk(tag, result, exp);
      chk({tag, "_v"}, {31'b0, valid_out}, 32'd1);
   endtask

   typedef struct { logic o; logic [31:0] x; logic [31:0] y; logic [31:0] e; } vec_t;

   initial begin
      vec_t        vecs[$];
      logic [31:0] last;
      logic [31:0] exp32;

      #1;
      chk("rst_result", result, 32'h0);
      chk("rst_valid", {31'b0, valid_out}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef FLOATING_ROUND_NEAREST_EN
      exp32 = 32'h3F800002;
`else
      exp32 = 32'h3F800001;
`endif
      vecs = '{
         '{1'b1, 32'h40000000, 32'h40400000, 32'h40C00000},
         '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000},
         '{1'b0, 32'h3FC00000, 32'hBFC00000, 32'h00000000},
         '{1'b1, 32'h7F000000, 32'h40000000, 32'h7F800000},
         '{1'b1, 32'h00000000, 32'h7F800000, 32'h7FC00000},
         '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000},
         '{1'b0, 32'h3F800001, 32'h33800000, exp32},
         '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000},
         '{1'b0, 32'h00000000, 32'h80000000, 32'h00000000},
         '{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000},
         '{1'b1, 32'hBF800000, 32'h7F800000, 32'hFF800000},
         '{1'b1, 32'h80000000, 32'h3F800000, 32'h80000000},
         '{1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000},
         '{1'b1, 32'h00400000, 32'h40000000, 32'h00000000},
         '{1'b1, 32'h80800000, 32'h3F000000, 32'h80000000},
         '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
         '{1'b0, 32'h40000000, 32'hBF800000, 32'h3F800000},
         '{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000},
         '{1'b1, 32'h3F800001, 32'h3F800001, 32'h3F800002}
      };
      foreach (vecs[i])
         apply($sformatf("dir%0d", i), vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].e);

      // idle cycle: valid drops, result holds
      last = result;
      @(negedge clk);
      valid_in = 1'b0;
      a = 32'h12345678;
      @(posedge clk);
      #1;
      chk("idle_valid", {31'b0, valid_out}, 32'd0);
      chk("idle_hold", result, last);

      // back-to-back random stream
      for (int i = 0; i < 300; i++) begin
         logic        o;
         logic [31:0] x, y;
         o = 1'($urandom);
         x = {1'($urandom), 8'($urandom_range(140, 115)), 23'($urandom)};
         y = {1'($urandom), 8'($urandom_range(140, 115)), 23'($urandom)};
         if (i % 17 == 0) y = {~x[31], x[30:0]};
         @(negedge clk);
         op = o; a = x; b = y; valid_in = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d", i), result, ref_fp(o, x, y));
         chk($sformatf("rnd%0d_v", i), {31'b0, valid_out}, 32'd1);
      end

      // three consecutive valids, then reset mid-cycle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         op = 1'b0; a = 32'h3F800000; b = 32'h3F800000; valid_in = 1'b1;
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_result", result, 32'h0);
      chk("midrst_valid", {31'b0, valid_out}, 32'd0);
      @(negedge clk);
      valid_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_rst_valid%0d", i), {31'b0, valid_out}, 32'd0);
         chk($sformatf("post_rst_result%0d", i), result, 32'h0);
      end

      // second reset, then sample on the very first edge after release
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      op = 1'b1; a = 32'h40000000; b = 32'h40400000; valid_in = 1'b1;
      @(posedge clk);
      #1;
      chk("first_edge_result", result, 32'h40C00000);
      chk("first_edge_valid", {31'b0, valid_out}, 32'd1);
      @(negedge clk);
      valid_in = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
